// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-branch logic: LEGv8 condition codes,
// branch kinds, NZCV bit positions and the branch unit's FSM states.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    BR_COND   = 2'b00,
    BR_CBZ    = 2'b01,
    BR_CBNZ   = 2'b10,
    BR_UNCOND = 2'b11
  } br_type_e;

  // NZCV register is packed as {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational LEGv8 condition-code decoder; kept standalone so a later
// conditional-select unit can reuse it.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b1;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_HS: pass = c;
      COND_LO: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// NZCV flag register plus registered branch decision (latency 1).
// Define COND_BRANCH_FLAG_FWD_EN to forward same-cycle ALU flags instead of stalling.
module cond_branch_unit
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flag_we,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_carry_out,
  input  logic       br_valid,
  input  logic [1:0] br_type,
  input  logic [3:0] br_cond,
  input  logic       cbz_zero,
  input  logic       flush,
  output logic [3:0] flags_q,
  output logic       taken,
  output logic       taken_valid,
  output logic       stall
);

  state_e     state, next_state;
  logic [3:0] alu_flags;
  logic [3:0] eval_flags;
  logic [3:0] eval_cond;
  logic [3:0] pend_cond;
  logic       hazard;
  logic       cond_pass;
  logic       capture;
  logic       dec_valid;
  logic       dec_taken;

  assign alu_flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};

`ifdef COND_BRANCH_FLAG_FWD_EN
  // The flag writer's result is visible to a B.cond in the same cycle, so no hazard exists
  assign eval_flags = flag_we ? alu_flags : flags_q;
  assign hazard     = 1'b0;
`else
  assign eval_flags = flags_q;
  assign hazard     = br_valid & flag_we & (br_type == BR_COND);
`endif

  assign eval_cond = (state == ST_PEND) ? pend_cond : br_cond;

  cond_eval u_cond_eval (
    .cond (eval_cond),
    .nzcv (eval_flags),
    .pass (cond_pass)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (hazard && !flush) next_state = ST_PEND;
      ST_PEND: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    capture   = 1'b0;
    dec_valid = 1'b0;
    dec_taken = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hazard) begin
          stall   = 1'b1;
          capture = 1'b1;
        end else if (br_valid) begin
          dec_valid = 1'b1;
          case (br_type)
            BR_COND: dec_taken = cond_pass;
            BR_CBZ:  dec_taken = cbz_zero;
            BR_CBNZ: dec_taken = !cbz_zero;
            default: dec_taken = 1'b1;
          endcase
        end
      end
      ST_PEND: begin
        // New requests are ignored here; the pending one resolves against the now-updated flags
        stall     = 1'b1;
        dec_valid = 1'b1;
        dec_taken = cond_pass;
      end
      default: ;
    endcase
    if (flush) dec_valid = 1'b0;
    if (!reset) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q     <= 4'b0000;
      pend_cond   <= 4'h0;
      taken       <= 1'b0;
      taken_valid <= 1'b0;
    end else begin
      if (flag_we) flags_q <= alu_flags;
      if (capture) pend_cond <= br_cond;
      taken_valid <= dec_valid;
      if (dec_valid) taken <= dec_taken;
    end
  end

endmodule

// File: doc/cond_branch_unit.md
COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have port flag_we, input, 1 bit: latch the ALU flags this cycle (flag-setting ops such as ADDS, SUBS, ANDS).
REQ-004 SHALL have ports alu_negative, alu_zero, alu_overflow and alu_carry_out, inputs, 1 bit each: ALU flag outputs.
REQ-005 SHALL have port br_valid, input, 1 bit: a branch request is presented this cycle.
REQ-006 SHALL have port br_type, input, 2 bits: 00 B.cond, 01 CBZ, 10 CBNZ, 11 B (unconditional).
REQ-007 SHALL have port br_cond, input, 4 bits: LEGv8 condition code, used only for B.cond.
REQ-008 SHALL have port cbz_zero, input, 1 bit: ALU zero output for the CBZ/CBNZ operand (ALU pass-B), not the stored flags.
REQ-009 SHALL have port flush, input, 1 bit: kill any in-flight branch decision.
REQ-010 SHALL have port flags_q, output, 4 bits: architectural NZCV register, ordered {N,Z,C,V}.
REQ-011 SHALL have port taken, output, 1 bit: registered branch decision.
REQ-012 SHALL have port taken_valid, output, 1 bit: taken is meaningful this cycle (one-cycle pulse).
REQ-013 SHALL have port stall, output, 1 bit, combinational: upstream holds and SHALL NOT present br_valid this cycle.

Function
REQ-014 SHALL load flags_q from {alu_negative, alu_zero, alu_carry_out, alu_overflow} on each edge where flag_we=1, and hold it otherwise.
REQ-015 SHALL evaluate br_cond as: 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E and F always true.
REQ-016 SHALL decide CBZ = cbz_zero, CBNZ = !cbz_zero and B = 1, independent of flags and flag_we.
REQ-017 SHALL register taken and pulse taken_valid=1 exactly one cycle after an accepted br_valid (latency 1), except in the PEND case of REQ-021.
REQ-018 SHALL set taken_valid=0 in every cycle with no decision to report; taken holds its last value.
REQ-019 SHALL have two states: IDLE and PEND.
REQ-020 SHALL, when flush=1, clear the decision for the next cycle (taken_valid=0) and return to IDLE; flags_q still updates if flag_we=1 because the flag writer is older than the flushed branch.
REQ-021 SHALL, without FLAG_FWD_EN, handle br_valid & br_type=B.cond & flag_we in the same cycle as follows: assert stall that cycle, capture br_cond, go to PEND, evaluate against the updated flags_q in PEND, pulse taken_valid on the cycle after PEND, then return to IDLE.
REQ-022 SHALL hold stall=1 while in PEND and ignore any br_valid received in PEND.
REQ-023 SHALL, when flush=1 in PEND, discard the pending branch and return to IDLE with no taken_valid.

Reset
REQ-024 SHALL, while reset=0, force flags_q=4'b0000, taken=0, taken_valid=0, stall=0 and state IDLE immediately, independent of clk.
REQ-025 SHALL abandon any branch pending at reset assertion, and SHALL accept a branch on the first edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro COND_BRANCH_FLAG_FWD_EN defined, forward same-cycle ALU flags into B.cond evaluation when flag_we=1; stall is then constant 0 and PEND is unreachable.
REQ-027 SHALL, without COND_BRANCH_FLAG_FWD_EN, evaluate only against flags_q and use the stall/PEND behaviour of REQ-021.

Structure
REQ-028 SHALL take the condition-code enum, the br_type enum and the NZCV bit-index constants from shared package cond_pkg.
REQ-029 SHALL instantiate one combinational sub-module, cond_eval (inputs: 4-bit cond and 4-bit NZCV; output: pass), so the decoder can be reused by a later conditional-select unit.

Verification
REQ-030 SHALL cover: flag_we with N=0,Z=1,C=1,V=0, then B.cond EQ (0x0) two cycles later -> taken=1, taken_valid one cycle after br_valid.
REQ-031 SHALL cover: flags N=1,V=0 latched, then B.cond GE (0xA) -> taken=0; then B.cond LT (0xB) -> taken=1.
REQ-032 SHALL cover: CBZ with cbz_zero=1 while flags_q Z=0 -> taken=1; CBNZ with cbz_zero=1 -> taken=0.
REQ-033 SHALL cover: flag_we (Z=1) and B.cond EQ in the same cycle -> with macro, taken=1 at latency 1 and stall=0; without macro, stall=1 for 2 cycles and taken=1 with taken_valid at cycle 2.
REQ-034 SHALL cover: the PEND case with flush=1 in PEND -> no taken_valid, state IDLE, flags_q updated.
REQ-035 SHALL cover: reset=0 asserted mid-PEND between clock edges -> all outputs 0 immediately, and a subsequent B (type 11) -> taken=1 at latency 1.
